hls_call_issuer: RTL
====================

Name: hls_call_issuer

Overview:
- Caller-side driver for the HLS component call/return streaming interface: start/busy, done/stall, returndata, plus the argument buses a (64-bit) and n (32-bit).
- Accepts call commands from an upstream valid/ready stream and presents them to the component with correct start/busy handshaking.
- Tracks outstanding invocations, with a credit limit, and matches each in-order returndata with its command tag.
- Buffers results into a downstream valid/ready response stream and asserts stall back to the component when that buffer is full.

Parameters:
- TAG_W, 4, width of the command/response tag.
- MAX_OUT, 4, maximum commands accepted but not yet returned (range 1..15).
- RSP_DEPTH, 4, result FIFO entries (power of two, at least 2).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  upstream command ready.
- cmd_a  in  64  argument a for the call.
- cmd_n  in  32  argument n for the call.
- cmd_tag  in  TAG_W  caller tag, returned with the result.
- start  out  1  call valid to the component.
- busy  in  1  component call stall.
- a  out  64  argument a to the component, held while start is high.
- n  out  32  argument n to the component, held while start is high.
- done  in  1  component return valid.
- stall  out  1  return stall to the component.
- returndata  in  32  component return data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_data  out  32  returned data.
- rsp_tag  out  TAG_W  tag of the matching command.
- idle  out  1  high when nothing is in flight and nothing is buffered.
- err_orphan_done  out  1  sticky error: a return arrived with no outstanding call.

Behaviour:
- Reset (asynchronous, active-high) clears all state. Output values during and after reset:
  - start=0, a=0, n=0, stall=0, cmd_ready=0 while reset is asserted.
  - rsp_valid=0, rsp_data=0, rsp_tag=0.
  - idle=1, err_orphan_done=0.
  - Tag FIFO, result FIFO and cnt are all emptied or zeroed.
- Reset mid-operation discards all pending, in-flight and buffered entries. No response is emitted for them. The component is reset by the same reset.
- Handshake definitions:
  - call_fire = start & ~busy.
  - ret_fire = done & ~stall.
  - cmd_fire = cmd_valid & cmd_ready.
  - rsp_fire = rsp_valid & rsp_ready.
- cnt is the number of commands accepted and not yet retired by ret_fire (range 0..MAX_OUT).
- cmd_ready = ~reset & (~start | ~busy) & (cnt < MAX_OUT).
  - A credit freed in the same cycle by ret_fire is not reusable until the next cycle.
- Issue register:
  - On cmd_fire, register cmd_a → a, cmd_n → n, cmd_tag → pending tag; start=1 from the next cycle.
  - start, a and n stay stable until call_fire.
  - On call_fire without a new cmd_fire, start=0 next cycle.
  - On call_fire with a new cmd_fire in the same cycle, load the new arguments and keep start=1 (back-to-back issue, one call per cycle).
  - On call_fire, push the pending tag into the tag FIFO (depth MAX_OUT).
- Returns are in order. On ret_fire with the tag FIFO non-empty:
  - pop the tag FIFO;
  - push {tag, returndata} into the result FIFO;
  - decrement cnt.
- ret_fire with the tag FIFO empty (orphan return):
  - set err_orphan_done (sticky until reset);
  - drop the data; cnt is unchanged.
- stall = result FIFO full. It is combinational from registered FIFO state, never from rsp_ready, so there is no path from rsp_ready to stall.
- Result FIFO is first-word-fall-through:
  - rsp_valid = not empty; rsp_data and rsp_tag show the head entry.
  - rsp_data and rsp_tag hold stable while rsp_valid & ~rsp_ready.
  - Simultaneous push and pop when full is not possible, because stall blocks the push.
  - Simultaneous push and pop in any other state keeps the count unchanged.
- Simultaneous cmd_fire and valid ret_fire leaves cnt unchanged.
- Pointers wrap modulo depth. The full/empty distinction uses an extra pointer bit.
- idle = (cnt==0) & ~start & result FIFO empty.
- Latency:
  - cmd_fire → start asserted: 1 cycle.
  - ret_fire → rsp_valid: 1 cycle.

Test Plan:
- Single call: send cmd a=0x1000, n=8, tag=3; hold busy=0; return done with returndata=0x2A two cycles later → exactly one start pulse with a=0x1000, n=8; rsp_valid one cycle after done with rsp_data=0x2A, rsp_tag=3; idle returns to 1.
- Busy hold: command a=0xDEAD_BEEF_0000_0010, n=5; hold busy=1 for 6 cycles → start, a and n held stable for all 6 cycles; the call is accepted in the first cycle busy=0; cmd_ready=0 while start&busy.
- Credit limit: MAX_OUT=4, busy=0, no done; offer 6 commands back-to-back with tags 0..5 → 4 start pulses on consecutive cycles, then cmd_ready=0. After one ret_fire, cmd_ready=1 on the next cycle and the 5th command issues.
- Backpressure: RSP_DEPTH=4, rsp_ready=0, return 5 results 0x10..0x14 → stall=1 after the 4th push; the 5th done is held until rsp_ready=1. Responses drain in order 0x10..0x14 with matching tags.
- Simultaneity: cmd_fire and ret_fire in the same cycle with cnt=2 → cnt stays 2. A push and pop of the result FIFO in the same cycle keeps its occupancy unchanged.
- Orphan return and reset: pulse done with no call outstanding → err_orphan_done=1 and no response emitted. Then assert reset mid-flight with 3 calls outstanding → all outputs return to reset values asynchronously, and no stale response appears after release.

Source files
------------

// File: rtl/hls_call_issuer.sv
// hls_call_issuer: caller-side driver for an HLS call/return stream.
// Issues calls under a credit limit and pairs in-order returns with tags.
module hls_call_issuer #(
  parameter int TAG_W     = 4,
  parameter int MAX_OUT   = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_a,
  input  logic [31:0]      cmd_n,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             start,
  input  logic             busy,
  output logic [63:0]      a,
  output logic [31:0]      n,
  input  logic             done,
  output logic             stall,
  input  logic [31:0]      returndata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             idle,
  output logic             err_orphan_done
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int TPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int RW  = TAG_W + 32;

  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] ptag;

  logic call_fire;
  logic ret_fire;
  logic cmd_fire;
  logic rsp_fire;
  logic retire;
  logic orphan;

  logic [TAG_W-1:0] tmem [MAX_OUT];
  logic [TPW-1:0]   twp;
  logic [TPW-1:0]   trp;
  logic [CW-1:0]    tcnt;
  logic             tempty;

  logic [RW-1:0] rmem [RSP_DEPTH];
  logic [RAW:0]  rwp;
  logic [RAW:0]  rrp;
  logic          rempty;
  logic          rfull;
  logic [RW-1:0] rhead;

  function automatic logic [TPW-1:0] tnext(
    input logic [TPW-1:0] p
  );
    if (p == TPW'(MAX_OUT - 1))
      return '0;
    return p + TPW'(1);
  endfunction

  assign tempty = (tcnt == '0);
  assign rempty = (rwp == rrp);
  assign rfull  = (rwp[RAW] != rrp[RAW]) &&
                  (rwp[RAW-1:0] == rrp[RAW-1:0]);

  // stall comes only from registered FIFO state
  assign stall     = rfull;
  assign call_fire = start & ~busy;
  assign ret_fire  = done & ~stall;
  assign cmd_ready = ~reset & (~start | ~busy) &
                     (cnt < CW'(MAX_OUT));
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign retire    = ret_fire & ~tempty;
  assign orphan    = ret_fire & tempty;

  assign rsp_valid = ~rempty;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign rhead     = rempty ? '0 : rmem[rrp[RAW-1:0]];
  assign rsp_tag   = rhead[RW-1:32];
  assign rsp_data  = rhead[31:0];

  assign idle = (cnt == '0) & ~start & rempty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start <= 1'b0;
      a     <= '0;
      n     <= '0;
      ptag  <= '0;
    end else if (cmd_fire) begin
      start <= 1'b1;
      a     <= cmd_a;
      n     <= cmd_n;
      ptag  <= cmd_tag;
    end else if (call_fire) begin
      start <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      unique case ({cmd_fire, retire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (call_fire)
      tmem[twp] <= ptag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      twp  <= '0;
      trp  <= '0;
      tcnt <= '0;
    end else begin
      if (call_fire)
        twp <= tnext(twp);
      if (retire)
        trp <= tnext(trp);
      unique case ({call_fire, retire})
        2'b10:   tcnt <= tcnt + CW'(1);
        2'b01:   tcnt <= tcnt - CW'(1);
        default: tcnt <= tcnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (retire)
      rmem[rwp[RAW-1:0]] <= {tmem[trp], returndata};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rwp <= '0;
      rrp <= '0;
    end else begin
      if (retire)
        rwp <= rwp + (RAW+1)'(1);
      if (rsp_fire)
        rrp <= rrp + (RAW+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_orphan_done <= 1'b0;
    else if (orphan)
      err_orphan_done <= 1'b1;
  end

endmodule
